// File: rtl/sparse_mm_pkg.sv
// Shared types and constants for the COO sparse x sparse FP8 matmul engine.
package sparse_mm_pkg;

    localparam int FRAC_BITS = 20;
    localparam int PROD_W    = 39;

    typedef struct packed {
        logic       sign;
        logic [3:0] exp;
        logic [2:0] man;
    } fp8_t;

    typedef struct packed {
        logic [7:0] row;
        logic [7:0] col;
        fp8_t       data;
        logic       last;
    } coo_entry_t;

    typedef enum logic [2:0] {IDLE, LOAD_B, STREAM_A, SCAN, DRAIN} spmm_state_e;

endpackage

// File: rtl/fp8_mul_fixed.sv
// Exact E4M3 x E4M3 product as a signed fixed-point value with 20 fractional bits.
module fp8_mul_fixed
    import sparse_mm_pkg::*;
(
    input  logic [7:0]               a,
    input  logic [7:0]               b,
    output logic signed [PROD_W-1:0] prod
);

    fp8_t              fa, fb;
    logic [7:0]        sig;
    logic [4:0]        sh;
    logic [PROD_W-2:0] mag;

    // Both operands carry bias 7, so (1.m)(1.m)*2^(ea+eb-14) scaled by 2^20
    // collapses to (8+ma)(8+mb) << (ea+eb) with no rounding anywhere.
    always_comb begin
        fa   = fp8_t'(a);
        fb   = fp8_t'(b);
        sig  = {5'b00001, fa.man} * {5'b00001, fb.man};
        sh   = {1'b0, fa.exp} + {1'b0, fb.exp};
        mag  = (PROD_W-1)'(sig) << sh;
        prod = '0;
        if (!((fa.exp == 4'd0 && fa.man == 3'd0) || (fb.exp == 4'd0 && fb.man == 3'd0)))
            prod = (fa.sign ^ fb.sign) ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    end

endmodule

// File: rtl/sparse_coo_spmm_stream.sv
// Streaming COO sparse x sparse FP8 matmul: buffers B, scans it once per A entry, drains dense C.
// Optional SPMM_SAT_EN: saturating accumulate plus sticky sat_flag output.
module sparse_coo_spmm_stream
    import sparse_mm_pkg::*;
#(
    parameter int N_ROWS  = 8,
    parameter int N_INNER = 8,
    parameter int N_COLS  = 8,
    parameter int NNZ_B   = 16,
    parameter int ACC_W   = 48
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [$clog2(N_INNER)-1:0] b_row,
    input  logic [$clog2(N_COLS)-1:0]  b_col,
    input  logic [7:0]                 b_data,
    input  logic                       b_last,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [$clog2(N_ROWS)-1:0]  a_row,
    input  logic [$clog2(N_INNER)-1:0] a_col,
    input  logic [7:0]                 a_data,
    input  logic                       a_last,
    output logic                       c_valid,
    input  logic                       c_ready,
    output logic [$clog2(N_ROWS)-1:0]  c_row,
    output logic [$clog2(N_COLS)-1:0]  c_col,
    output logic [ACC_W-1:0]           c_data,
    output logic                       c_last,
`ifdef SPMM_SAT_EN
    output logic                       sat_flag,
`endif
    output logic                       err_ovf
);

    localparam int RW  = $clog2(N_ROWS);
    localparam int IW  = $clog2(N_INNER);
    localparam int CLW = $clog2(N_COLS);
    localparam int CW  = $clog2(NNZ_B + 1);
    localparam int KW  = $clog2(NNZ_B);

    spmm_state_e state, nxt;

    logic [IW-1:0]  b_row_mem [NNZ_B];
    logic [CLW-1:0] b_col_mem [NNZ_B];
    logic [7:0]     b_dat_mem [NNZ_B];
    logic [CW-1:0]  b_count;
    logic [KW-1:0]  k;

    logic [RW-1:0]  a_row_l;
    logic [IW-1:0]  a_col_l;
    logic [7:0]     a_dat_l;
    logic           a_last_l;

    logic signed [ACC_W-1:0] acc [N_ROWS][N_COLS];
    logic [RW-1:0]  dr_row;
    logic [CLW-1:0] dr_col;
    logic           err_q;
`ifdef SPMM_SAT_EN
    logic           sat_q;
    logic           clamp;
    logic [ACC_W:0] sum;
`endif

    logic                    b_bad, a_bad, scan_end, hit, drain_end;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext, acc_cur, acc_new;

    fp8_mul_fixed u_mul (
        .a    (a_dat_l),
        .b    (b_dat_mem[k]),
        .prod (prod)
    );

    always_comb begin
        b_bad     = 32'(b_row) >= N_INNER || 32'(b_col) >= N_COLS || 32'(b_count) >= NNZ_B;
        a_bad     = 32'(a_row) >= N_ROWS || 32'(a_col) >= N_INNER;
        scan_end  = (b_count == '0) || (32'(k) + 1 == 32'(b_count));
        hit       = (state == SCAN) && (b_count != '0) && (b_row_mem[k] == a_col_l);
        drain_end = (32'(dr_row) == N_ROWS - 1) && (32'(dr_col) == N_COLS - 1);
        prod_ext  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        acc_cur   = acc[a_row_l][b_col_mem[k]];
`ifdef SPMM_SAT_EN
        // One guard bit catches overflow; clamp toward the sign of the true sum.
        sum     = {acc_cur[ACC_W-1], acc_cur} + {prod_ext[ACC_W-1], prod_ext};
        clamp   = sum[ACC_W] ^ sum[ACC_W-1];
        acc_new = clamp ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
`else
        acc_new = acc_cur + prod_ext;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     if (start) nxt = LOAD_B;
            LOAD_B:   if (b_valid && b_last) nxt = STREAM_A;
            STREAM_A: if (a_valid) begin
                          if (!a_bad)     nxt = SCAN;
                          else if (a_last) nxt = DRAIN;
                      end
            SCAN:     if (scan_end) nxt = a_last_l ? DRAIN : STREAM_A;
            DRAIN:    if (c_ready && drain_end) nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        b_ready = (state == LOAD_B);
        a_ready = (state == STREAM_A);
        c_valid = (state == DRAIN);
        c_row   = c_valid ? dr_row : '0;
        c_col   = c_valid ? dr_col : '0;
        c_data  = c_valid ? acc[dr_row][dr_col] : '0;
        c_last  = c_valid && drain_end;
        err_ovf = err_q;
`ifdef SPMM_SAT_EN
        sat_flag = sat_q;
`endif
    end

    // B storage is only ever read below b_count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == LOAD_B && b_valid && !b_bad) begin
            b_row_mem[b_count[KW-1:0]] <= b_row;
            b_col_mem[b_count[KW-1:0]] <= b_col;
            b_dat_mem[b_count[KW-1:0]] <= b_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_count  <= '0;
            k        <= '0;
            a_row_l  <= '0;
            a_col_l  <= '0;
            a_dat_l  <= '0;
            a_last_l <= 1'b0;
            dr_row   <= '0;
            dr_col   <= '0;
            err_q    <= 1'b0;
`ifdef SPMM_SAT_EN
            sat_q    <= 1'b0;
`endif
            for (int r = 0; r < N_ROWS; r++)
                for (int c = 0; c < N_COLS; c++)
                    acc[r][c] <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    b_count <= '0;
                    dr_row  <= '0;
                    dr_col  <= '0;
                    err_q   <= 1'b0;
`ifdef SPMM_SAT_EN
                    sat_q   <= 1'b0;
`endif
                    for (int r = 0; r < N_ROWS; r++)
                        for (int c = 0; c < N_COLS; c++)
                            acc[r][c] <= '0;
                end
                LOAD_B: if (b_valid) begin
                    if (b_bad) err_q   <= 1'b1;
                    else       b_count <= b_count + 1'b1;
                end
                STREAM_A: if (a_valid) begin
                    if (a_bad) err_q <= 1'b1;
                    else begin
                        a_row_l  <= a_row;
                        a_col_l  <= a_col;
                        a_dat_l  <= a_data;
                        a_last_l <= a_last;
                        k        <= '0;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        acc[a_row_l][b_col_mem[k]] <= acc_new;
`ifdef SPMM_SAT_EN
                        if (clamp) sat_q <= 1'b1;
`endif
                    end
                    if (!scan_end) k <= k + 1'b1;
                end
                DRAIN: if (c_ready) begin
                    if (32'(dr_col) == N_COLS - 1) begin
                        dr_col <= '0;
                        dr_row <= drain_end ? '0 : dr_row + 1'b1;
                    end else begin
                        dr_col <= dr_col + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_coo_spmm_stream.sv
// Randomized and directed bench for sparse_coo_spmm_stream against a dense-matrix reference model.
module tb_sparse_coo_spmm_stream;

    localparam int NR = 8, NI = 8, NC = 8, NB = 16, AW = 48;

    logic clk = 0, rst_n = 0, start = 0;
    logic busy, b_ready, a_ready, c_valid, c_last, err_ovf;
    logic b_valid = 0, b_last = 0, a_valid = 0, a_last = 0, c_ready = 0;
    logic [2:0] b_row = 0, b_col = 0, a_row = 0, a_col = 0;
    logic [7:0] b_data = 0, a_data = 0;
    logic [2:0] c_row, c_col;
    logic [AW-1:0] c_data;
`ifdef SPMM_SAT_EN
    logic sat_flag;
`endif

    sparse_coo_spmm_stream #(.N_ROWS(NR), .N_INNER(NI), .N_COLS(NC), .NNZ_B(NB), .ACC_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .b_valid(b_valid), .b_ready(b_ready), .b_row(b_row), .b_col(b_col), .b_data(b_data), .b_last(b_last),
        .a_valid(a_valid), .a_ready(a_ready), .a_row(a_row), .a_col(a_col), .a_data(a_data), .a_last(a_last),
        .c_valid(c_valid), .c_ready(c_ready), .c_row(c_row), .c_col(c_col), .c_data(c_data), .c_last(c_last),
`ifdef SPMM_SAT_EN
        .sat_flag(sat_flag),
`endif
        .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    typedef struct { int row; int col; logic [7:0] d; } ent_t;
    ent_t   bq[$], aq[$];
    longint cref [NR][NC];
    bit     sat_ref;
    int     n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Real value of an E4M3 number times 2^10, so a product lands at 2^20 scale.
    function automatic longint fp8_mag(input logic [7:0] v);
        int e, m;
        e = int'(v[6:3]);
        m = int'(v[2:0]);
        if (e == 0 && m == 0) return 0;
        return longint'(8 + m) <<< e;
    endfunction

    function automatic longint sext_acc(input longint v);
        logic [63:0] x;
        x = v;
        x[63:AW] = {(64-AW){x[AW-1]}};
        return longint'(x);
    endfunction

    task automatic model();
        int     nb;
        longint p, s;
        longint hi, lo;
        hi = (longint'(1) <<< (AW-1)) - 1;
        lo = -(longint'(1) <<< (AW-1));
        sat_ref = 0;
        foreach (cref[r, c]) cref[r][c] = 0;
        nb = (bq.size() > NB) ? NB : bq.size();
        foreach (aq[i])
            for (int j = 0; j < nb; j++)
                if (bq[j].row == aq[i].col) begin
                    p = fp8_mag(aq[i].d) * fp8_mag(bq[j].d);
                    if (aq[i].d[7] ^ bq[j].d[7]) p = -p;
                    s = cref[aq[i].row][bq[j].col] + p;
`ifdef SPMM_SAT_EN
                    if (s > hi) begin s = hi; sat_ref = 1; end
                    if (s < lo) begin s = lo; sat_ref = 1; end
`else
                    s = sext_acc(s);
`endif
                    cref[aq[i].row][bq[j].col] = s;
                end
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic send_b();
        foreach (bq[i]) begin
            int t = 0;
            b_valid = 1; b_row = 3'(bq[i].row); b_col = 3'(bq[i].col);
            b_data = bq[i].d; b_last = (i == bq.size() - 1);
            @(negedge clk);
            while (!b_ready && t < 100) begin t++; @(negedge clk); end
            if (!b_ready) chk("b_ready_timeout", 0, 1);
            @(posedge clk); #1;
        end
        b_valid = 0; b_last = 0;
    endtask

    task automatic send_a();
        foreach (aq[i]) begin
            int t = 0;
            a_valid = 1; a_row = 3'(aq[i].row); a_col = 3'(aq[i].col);
            a_data = aq[i].d; a_last = (i == aq.size() - 1);
            @(negedge clk);
            while (!a_ready && t < 100) begin t++; @(negedge clk); end
            if (!a_ready) chk("a_ready_timeout", 0, 1);
            @(posedge clk); #1;
        end
        a_valid = 0; a_last = 0;
    endtask

    // mode 0: always ready, 1: toggling ready, 2: random ready
    task automatic drain(input int mode, input bit exp_err);
        int idx = 0, t = 0;
        bit held = 0;
        logic [2:0] hr, hc;
        logic [AW-1:0] hd;
        while (idx < NR*NC && t < 3000) begin
            @(posedge clk); #1;
            case (mode)
                0:       c_ready = 1;
                1:       c_ready = (t % 2 == 0);
                default: c_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            t++;
            if (held) begin
                chk("hold_valid", c_valid, 1);
                chk("hold_idx", {c_row, c_col}, {hr, hc});
                chk("hold_data", longint'($signed(c_data)), longint'($signed(hd)));
            end
            held = 0;
            if (c_valid) begin
                if (c_ready) begin
                    chk("beat_idx", int'({c_row, c_col}), idx);
                    chk("beat_data", longint'($signed(c_data)), cref[idx / NC][idx % NC]);
                    chk("beat_last", c_last, idx == NR*NC - 1);
                    if (idx == 0) chk("err_ovf", err_ovf, exp_err);
                    idx++;
                end else begin
                    held = 1; hr = c_row; hc = c_col; hd = c_data;
                end
            end
        end
        chk("beat_count", idx, NR*NC);
        @(posedge clk); #1 c_ready = 0;
        @(negedge clk);
        chk("idle_after_drain", busy, 0);
    endtask

    task automatic run_case(input int mode, input bit exp_err);
        do_start();
        chk("err_clear_on_start", err_ovf, 0);
        send_b();
        send_a();
        model();
        drain(mode, exp_err);
    endtask

    task automatic test1_lists();
        bq.delete(); aq.delete();
        bq.push_back('{0, 0, 8'h38});
        aq.push_back('{0, 0, 8'h40});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {busy, b_ready, a_ready, c_valid, c_last, err_ovf}, 0);
        chk("rst_data", longint'(c_data), 0);
        rst_n = 1;

        // 1: single product 1.0 * 2.0
        test1_lists();
        run_case(0, 0);

        // 2: cancellation of +1.5 and -1.5
        bq.delete(); aq.delete();
        bq.push_back('{2, 3, 8'h3C});
        aq.push_back('{1, 2, 8'h38});
        aq.push_back('{1, 2, 8'hB8});
        run_case(0, 0);

        // 3: 17 B beats, the 17th is dropped
        bq.delete(); aq.delete();
        for (int i = 0; i < 17; i++) bq.push_back('{0, $urandom_range(0, 7), 8'($urandom_range(1, 255))});
        aq.push_back('{0, 0, 8'h3A});
        run_case(2, 1);

        // 4: toggling c_ready
        test1_lists();
        run_case(1, 0);

        // 5: reset while scanning, then a clean rerun
        bq.delete(); aq.delete();
        for (int i = 0; i < 16; i++) bq.push_back('{i % 8, i % 8, 8'h38});
        do_start();
        send_b();
        a_valid = 1; a_row = 3; a_col = 2; a_data = 8'h40; a_last = 1;
        @(negedge clk);
        @(posedge clk); #1 a_valid = 0; a_last = 0;
        @(negedge clk);
        chk("in_scan", {busy, a_ready, b_ready}, 3'b100);
        rst_n = 0;
        #1;
        chk("rst_mid_ctrl", {busy, b_ready, a_ready, c_valid, c_last, err_ovf}, 0);
        chk("rst_mid_idx", {c_row, c_col}, 0);
        chk("rst_mid_data", longint'(c_data), 0);
        @(posedge clk); #1 rst_n = 1;
        test1_lists();
        run_case(0, 0);

        // 6: 600 maximal products into one cell
        bq.delete(); aq.delete();
        bq.push_back('{0, 0, 8'h7F});
        for (int i = 0; i < 600; i++) aq.push_back('{0, 0, 8'h7F});
        run_case(0, 0);
`ifdef SPMM_SAT_EN
        chk("sat_flag", sat_flag, sat_ref);
`endif

        // randomized lists
        for (int it = 0; it < 6; it++) begin
            int nb, na;
            logic [7:0] d;
            bq.delete(); aq.delete();
            nb = $urandom_range(1, 16);
            na = $urandom_range(1, 12);
            for (int i = 0; i < nb; i++) begin
                d = 8'($urandom);
                if ($urandom_range(0, 7) == 0) d = {1'($urandom), 7'h0};
                bq.push_back('{$urandom_range(0, 3), $urandom_range(0, 7), d});
            end
            for (int i = 0; i < na; i++) begin
                d = 8'($urandom);
                if ($urandom_range(0, 7) == 0) d = {1'($urandom), 7'h0};
                aq.push_back('{$urandom_range(0, 7), $urandom_range(0, 3), d});
            end
            run_case(2, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
